l2_expr_sequencer: RTL and testbench

Front-end sequencer that drives the Lab 2 ASCII adder/subtractor from a UART receive byte stream. It parses a typed expression `<hex><op><hex>=`, presents both operand characters and the subtract flag to the adder, and pulses its data-ready input. It then captures the adder's ASCII result on the adder's ready pulse and streams the result plus CR/LF to the UART transmitter over a valid/ready handshake.

---
 rtl/l2_seq_pkg.sv | 15 +
 rtl/l2_tx_byte_port.sv | 30 +++
 rtl/l2_expr_sequencer.sv | 108 ++++++++++
 tb/tb_l2_expr_sequencer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/l2_seq_pkg.sv
// l2_seq_pkg: sequencer state encoding, ASCII constants and the lowercase-hex test
package l2_seq_pkg;
   typedef enum logic [3:0] {S_OP1, S_OPR, S_OP2, S_EQ, S_ISSUE, S_WAIT, S_RES, S_CR, S_LF} state_t;
   localparam logic [7:0] CH_PLUS  = 8'h2B;
   localparam logic [7:0] CH_MINUS = 8'h2D;
   localparam logic [7:0] CH_EQ    = 8'h3D;
   localparam logic [7:0] CH_CR    = 8'h0D;
   localparam logic [7:0] CH_LF    = 8'h0A;
   localparam logic [7:0] CH_SP    = 8'h20;
   localparam logic [7:0] CH_ERR   = 8'h3F;
   localparam logic [7:0] CH_TMO   = 8'h21;
   function automatic logic is_hex_lc(input logic [7:0] c);
      return (c >= 8'h30 && c <= 8'h39) || (c >= 8'h61 && c <= 8'h66);
   endfunction
endpackage

// File: rtl/l2_tx_byte_port.sv
// l2_tx_byte_port: one-byte holding register towards the UART transmitter
// ports: i_load/i_data load a byte; o_valid/o_data/i_ready form the valid/ready
// handshake; o_busy is high while a byte is held and not yet accepted.
module l2_tx_byte_port (
   input  logic       i_clk_in,
   input  logic       i_rst_n,
   input  logic       i_load,
   input  logic [7:0] i_data,
   input  logic       i_ready,
   output logic       o_valid,
   output logic [7:0] o_data,
   output logic       o_busy
);
   logic       r_valid;
   logic [7:0] r_data;
   always_ff @(posedge i_clk_in or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_valid <= 1'b0;
         r_data  <= 8'h00;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_data  <= i_data;
      end else if (r_valid && i_ready) begin
         r_valid <= 1'b0;
      end
   end
   assign o_valid = r_valid;
   assign o_data  = r_data;
   assign o_busy  = r_valid;
endmodule

// File: rtl/l2_expr_sequencer.sv
// l2_expr_sequencer: parses "<hex><op><hex>=" from UART RX, drives the ASCII adder, returns result+CR/LF
// ports: i_rx_data/i_rx_valid RX byte stream; o_r1/o_r2/o_substract_signal/o_data_rdy
// adder operands and issue pulse; i_adder_data/i_adder_rdy adder result; o_tx_data/
// o_tx_valid/i_tx_ready TX handshake; o_busy high outside S_OP1.
module l2_expr_sequencer
   import l2_seq_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic       i_clk_in,
   input  logic       i_rst_n,
   input  logic [7:0] i_rx_data,
   input  logic       i_rx_valid,
   output logic [7:0] o_r1,
   output logic [7:0] o_r2,
   output logic       o_substract_signal,
   output logic       o_data_rdy,
   input  logic [7:0] i_adder_data,
   input  logic       i_adder_rdy,
   output logic [7:0] o_tx_data,
   output logic       o_tx_valid,
   input  logic       i_tx_ready,
   output logic       o_busy
);
   localparam logic [7:0] LP_TMO = 8'(TIMEOUT_CYCLES);
   state_t     r_state, w_next;
   logic [7:0] r_r1, r_r2, r_resp, r_cnt, w_tx_d;
   logic       r_sub;
   logic       w_rx, w_hex, w_err, w_lat1, w_lat2, w_latop, w_load, w_tx_busy, w_done, w_tx_st;
   assign w_rx    = i_rx_valid && (i_rx_data != CH_SP);
   assign w_hex   = is_hex_lc(i_rx_data);
   assign w_done  = o_tx_valid && i_tx_ready;
   assign w_tx_st = (r_state == S_RES) || (r_state == S_CR) || (r_state == S_LF);
   // each TX state loads its byte once the port is empty and advances on the handshake
   assign w_load  = w_tx_st && !w_tx_busy;
   assign w_tx_d  = (r_state == S_RES) ? r_resp : (r_state == S_CR) ? CH_CR : CH_LF;
   always_ff @(posedge i_clk_in or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= S_OP1;
      else r_state <= w_next;
   end
   always_comb begin
      w_next  = r_state;
      w_err   = 1'b0;
      w_lat1  = 1'b0;
      w_lat2  = 1'b0;
      w_latop = 1'b0;
      case (r_state)
         S_OP1: if (w_rx) begin
            w_lat1 = w_hex;
            w_err  = !w_hex;
            w_next = w_hex ? S_OPR : S_RES;
         end
         S_OPR: if (w_rx) begin
            w_latop = (i_rx_data == CH_PLUS) || (i_rx_data == CH_MINUS);
            w_err   = !w_latop;
            w_next  = w_latop ? S_OP2 : S_RES;
         end
         S_OP2: if (w_rx) begin
            w_lat2 = w_hex;
            w_err  = !w_hex;
            w_next = w_hex ? S_EQ : S_RES;
         end
         S_EQ: if (w_rx) begin
            w_err  = !((i_rx_data == CH_EQ) || (i_rx_data == CH_CR));
            w_next = w_err ? S_RES : S_ISSUE;
         end
         S_ISSUE: w_next = S_WAIT;
         S_WAIT:  if (i_adder_rdy || r_cnt == 8'd0) w_next = S_RES;
         S_RES:   if (w_done) w_next = S_CR;
         S_CR:    if (w_done) w_next = S_LF;
         S_LF:    if (w_done) w_next = S_OP1;
         default: w_next = S_OP1;
      endcase
   end
   always_ff @(posedge i_clk_in or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_r1   <= 8'h30;
         r_r2   <= 8'h30;
         r_sub  <= 1'b0;
         r_resp <= CH_ERR;
         r_cnt  <= 8'd0;
      end else begin
         if (w_lat1) r_r1 <= i_rx_data;
         if (w_lat2) r_r2 <= i_rx_data;
         if (w_latop) r_sub <= (i_rx_data == CH_MINUS);
         // while waiting the response tracks rdy/timeout; only the value at exit matters
         if (w_err) r_resp <= CH_ERR;
         else if (r_state == S_WAIT) r_resp <= i_adder_rdy ? i_adder_data : CH_TMO;
         if (r_state == S_ISSUE) r_cnt <= LP_TMO;
         else if (r_state == S_WAIT && r_cnt != 8'd0) r_cnt <= r_cnt - 8'd1;
      end
   end
   l2_tx_byte_port u_tx (
      .i_clk_in (i_clk_in),
      .i_rst_n  (i_rst_n),
      .i_load   (w_load),
      .i_data   (w_tx_d),
      .i_ready  (i_tx_ready),
      .o_valid  (o_tx_valid),
      .o_data   (o_tx_data),
      .o_busy   (w_tx_busy)
   );
   assign o_r1               = r_r1;
   assign o_r2               = r_r2;
   assign o_substract_signal = r_sub;
   assign o_data_rdy         = (r_state == S_ISSUE);
   assign o_busy             = (r_state != S_OP1);
endmodule

// File: tb/tb_l2_expr_sequencer.sv
// tb_l2_expr_sequencer: directed-vector bench with an adder model and a TX byte logger
module tb_l2_expr_sequencer;
   logic       i_clk_in, i_rst_n, i_rx_valid, i_adder_rdy, i_tx_ready;
   logic [7:0] i_rx_data, i_adder_data;
   logic [7:0] o_r1, o_r2, o_tx_data;
   logic       o_substract_signal, o_data_rdy, o_tx_valid, o_busy;
   int         total = 0, bad = 0;
   logic [7:0] tx_log [0:255];
   int         tx_n = 0, tx_rd = 0, drdy_cnt = 0, d0;
   int         stale_req = 0, stale_seen = 0;
   logic       adder_on = 1'b1;
   logic [7:0] adder_resp = 8'h37;
   logic       ok;

   l2_expr_sequencer #(.TIMEOUT_CYCLES(16)) dut (
      .i_clk_in           (i_clk_in),
      .i_rst_n            (i_rst_n),
      .i_rx_data          (i_rx_data),
      .i_rx_valid         (i_rx_valid),
      .o_r1               (o_r1),
      .o_r2               (o_r2),
      .o_substract_signal (o_substract_signal),
      .o_data_rdy         (o_data_rdy),
      .i_adder_data       (i_adder_data),
      .i_adder_rdy        (i_adder_rdy),
      .o_tx_data          (o_tx_data),
      .o_tx_valid         (o_tx_valid),
      .i_tx_ready         (i_tx_ready),
      .o_busy             (o_busy)
   );

   initial begin
      i_clk_in = 1'b0;
      forever #5 i_clk_in = ~i_clk_in;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=running exp=finished");
      $fatal(1);
   end

   // logs every accepted TX byte and counts o_data_rdy cycles
   initial forever begin
      @(negedge i_clk_in);
      if (o_tx_valid && i_tx_ready) begin
         tx_log[tx_n[7:0]] = o_tx_data;
         tx_n++;
      end
      if (o_data_rdy) drdy_cnt++;
   end

   // adder model: result pulse on the 4th edge after the issue cycle; also injects stale pulses
   initial begin
      i_adder_rdy  = 1'b0;
      i_adder_data = 8'h00;
      forever begin
         @(negedge i_clk_in);
         if (stale_req != stale_seen) begin
            stale_seen = stale_req;
            @(posedge i_clk_in); #1;
            i_adder_data = 8'h55;
            i_adder_rdy  = 1'b1;
            @(posedge i_clk_in); #1;
            i_adder_rdy  = 1'b0;
         end else if (o_data_rdy && adder_on) begin
            repeat (3) @(posedge i_clk_in);
            #1;
            i_adder_data = adder_resp;
            i_adder_rdy  = 1'b1;
            @(posedge i_clk_in); #1;
            i_adder_rdy  = 1'b0;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge i_clk_in);
      #1;
   endtask

   task automatic rx(input logic [7:0] b);
      i_rx_data  = b;
      i_rx_valid = 1'b1;
      cyc(1);
      i_rx_valid = 1'b0;
   endtask

   task automatic rx_str(input string s);
      for (int i = 0; i < s.len(); i++) rx(s[i]);
   endtask

   task automatic wait_idle(input string tag);
      for (int i = 0; i < 300 && o_busy; i++) cyc(1);
      chk({tag, "_idle"}, o_busy, 1'b0);
   endtask

   task automatic expect_tx(input string tag, input logic [7:0] b0);
      logic [7:0] e [0:2];
      e[0] = b0;
      e[1] = 8'h0D;
      e[2] = 8'h0A;
      wait_idle(tag);
      chk({tag, "_txn"}, tx_n - tx_rd, 3);
      for (int i = 0; i < 3; i++) begin
         chk({tag, "_tx"}, (tx_rd < tx_n) ? {24'h0, tx_log[tx_rd[7:0]]} : 32'hDEAD, {24'h0, e[i]});
         if (tx_rd < tx_n) tx_rd++;
      end
      tx_rd = tx_n;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_r1"}, o_r1, 8'h30);
      chk({tag, "_r2"}, o_r2, 8'h30);
      chk({tag, "_sub"}, o_substract_signal, 1'b0);
      chk({tag, "_drdy"}, o_data_rdy, 1'b0);
      chk({tag, "_txv"}, o_tx_valid, 1'b0);
      chk({tag, "_txd"}, o_tx_data, 8'h00);
      chk({tag, "_busy"}, o_busy, 1'b0);
   endtask

   initial begin
      i_rst_n = 1'b1; i_rx_valid = 1'b0; i_rx_data = 8'h00; i_tx_ready = 1'b1;
      #2 i_rst_n = 1'b0;
      #1 chk_reset("rst");
      cyc(2);
      i_rst_n = 1'b1;
      cyc(1);

      d0 = drdy_cnt; adder_resp = 8'h37;
      rx_str("3+4=");
      chk("add_drdy", o_data_rdy, 1'b1);
      chk("add_r1", o_r1, 8'h33);
      chk("add_r2", o_r2, 8'h34);
      chk("add_sub", o_substract_signal, 1'b0);
      expect_tx("add", 8'h37);
      chk("add_npulse", drdy_cnt - d0, 1);

      d0 = drdy_cnt;
      rx_str("9 - 2");
      rx(8'h0D);
      chk("sub_drdy", o_data_rdy, 1'b1);
      chk("sub_r1", o_r1, 8'h39);
      chk("sub_r2", o_r2, 8'h32);
      chk("sub_sub", o_substract_signal, 1'b1);
      expect_tx("sub", 8'h37);
      chk("sub_npulse", drdy_cnt - d0, 1);

      d0 = drdy_cnt;
      rx("g");
      expect_tx("errg", 8'h3F);
      chk("errg_npulse", drdy_cnt - d0, 0);
      adder_resp = 8'h32;
      rx_str("1+1=");
      chk("one_r1", o_r1, 8'h31);
      expect_tx("one", 8'h32);
      d0 = drdy_cnt;
      rx("A");
      expect_tx("errA", 8'h3F);
      chk("errA_npulse", drdy_cnt - d0, 0);

      stale_req++;
      cyc(5);
      chk("stale_busy", o_busy, 1'b0);
      chk("stale_txn", tx_n - tx_rd, 0);
      adder_on = 1'b0;
      rx_str("5+5=");
      expect_tx("tmo", 8'h21);
      adder_on = 1'b1;

      i_tx_ready = 1'b0; adder_resp = 8'h34;
      rx_str("2+2=");
      for (int i = 0; i < 50 && !o_tx_valid; i++) cyc(1);
      ok = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (!o_tx_valid || o_tx_data !== 8'h34 || !o_busy) ok = 1'b0;
         rx(8'h31);
      end
      chk("stall_hold", ok, 1'b1);
      chk("stall_txd", o_tx_data, 8'h34);
      i_tx_ready = 1'b1;
      expect_tx("stall", 8'h34);
      cyc(3);
      chk("stall_drop", o_busy, 1'b0);

      adder_on = 1'b0;
      rx_str("7+1=");
      cyc(3);
      i_rst_n = 1'b0;
      #1 chk_reset("rstw");
      cyc(1);
      i_rst_n = 1'b1;
      adder_on = 1'b1; adder_resp = 8'h32;
      rx_str("1+1=");
      for (int i = 0; i < 50 && tx_n == tx_rd; i++) cyc(1);
      i_tx_ready = 1'b0;
      cyc(2);
      i_rst_n = 1'b0;
      #1 chk_reset("rstc");
      cyc(1);
      i_rst_n = 1'b1;
      i_tx_ready = 1'b1;
      tx_rd = tx_n;
      cyc(1);

      adder_resp = 8'h31;
      rx_str("f-e=");
      chk("fe_r1", o_r1, 8'h66);
      chk("fe_r2", o_r2, 8'h65);
      chk("fe_sub", o_substract_signal, 1'b1);
      expect_tx("fe", 8'h31);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
